// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller between EX/MEM and MEM/WB
//
// Purpose: issues one data-memory request per load/store from the EX/MEM
// register, stalls upstream until MEM_ACK or timeout, checks word alignment
// and registers the writeback-side results.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   MEMWRITE_IN, MEMTOREG_IN,
//   REGWRITE_IN, RESULTOP_IN,
//   WRDATA_IN, ARD_IN                 EX/MEM register outputs
//   MEM_REQ, MEM_WE, MEM_ADDR,
//   MEM_WDATA                         registered memory request
//   MEM_RDATA, MEM_ACK                memory response
//   STALL                             combinational upstream hold
//   MEMTOREG_OUT, REGWRITE_OUT,
//   RESULTOP_OUT, RDDATA_OUT, ARD_OUT registered MEM/WB results
//   MISALIGN_OUT, TIMEOUT_OUT         one-cycle fault flags

module mem_stage_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEMWRITE_IN,
  input  logic             MEMTOREG_IN,
  input  logic             REGWRITE_IN,
  input  logic [WIDTH-1:0] RESULTOP_IN,
  input  logic [WIDTH-1:0] WRDATA_IN,
  input  logic [4:0]       ARD_IN,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic [WIDTH-1:0] MEM_ADDR,
  output logic [WIDTH-1:0] MEM_WDATA,
  input  logic [WIDTH-1:0] MEM_RDATA,
  input  logic             MEM_ACK,
  output logic             STALL,
  output logic             MEMTOREG_OUT,
  output logic             REGWRITE_OUT,
  output logic [WIDTH-1:0] RESULTOP_OUT,
  output logic [WIDTH-1:0] RDDATA_OUT,
  output logic [4:0]       ARD_OUT,
  output logic             MISALIGN_OUT,
  output logic             TIMEOUT_OUT
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             req_nx, we_nx, memtoreg_nx, regwrite_nx, mis_nx, tmo_nx;
  logic [WIDTH-1:0] addr_nx, wdata_nx, resultop_nx, rddata_nx;
  logic [4:0]       ard_nx;

  logic need_access, aligned, at_limit, finishing;

  assign need_access = MEMWRITE_IN | MEMTOREG_IN;
  assign aligned     = (RESULTOP_IN[1:0] == 2'b00);
  assign at_limit    = (cnt == CNT_LAST);
  // The last ACCESS cycle (ack or abort) releases the pipeline so the
  // completing instruction's results load on the same edge.
  assign finishing   = (state == ACCESS) & (MEM_ACK | at_limit);
  // Gated by rst so an abandoned access never holds the pipeline in reset.
  assign STALL       = ~rst & need_access & aligned & ~finishing;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    req_nx      = MEM_REQ;
    we_nx       = MEM_WE;
    addr_nx     = MEM_ADDR;
    wdata_nx    = MEM_WDATA;
    // Writeback bubble unless a branch below commits the instruction.
    memtoreg_nx = 1'b0;
    regwrite_nx = 1'b0;
    resultop_nx = RESULTOP_IN;
    ard_nx      = ARD_IN;
    rddata_nx   = '0;
    mis_nx      = 1'b0;
    tmo_nx      = 1'b0;

    case (state)
      IDLE: begin
        if (!need_access) begin
          memtoreg_nx = MEMTOREG_IN;
          regwrite_nx = REGWRITE_IN;
        end else if (!aligned) begin
          mis_nx = 1'b1;
        end else begin
          addr_nx  = RESULTOP_IN;
          we_nx    = MEMWRITE_IN;
          wdata_nx = WRDATA_IN;
          req_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (MEM_ACK) begin
          req_nx      = 1'b0;
          state_nx    = IDLE;
          memtoreg_nx = MEMTOREG_IN;
          regwrite_nx = REGWRITE_IN;
          rddata_nx   = MEMTOREG_IN ? MEM_RDATA : '0;
        end else if (at_limit) begin
          req_nx   = 1'b0;
          state_nx = IDLE;
          tmo_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      MEM_REQ      <= 1'b0;
      MEM_WE       <= 1'b0;
      MEM_ADDR     <= '0;
      MEM_WDATA    <= '0;
      MEMTOREG_OUT <= 1'b0;
      REGWRITE_OUT <= 1'b0;
      RESULTOP_OUT <= '0;
      RDDATA_OUT   <= '0;
      ARD_OUT      <= '0;
      MISALIGN_OUT <= 1'b0;
      TIMEOUT_OUT  <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      MEM_REQ      <= req_nx;
      MEM_WE       <= we_nx;
      MEM_ADDR     <= addr_nx;
      MEM_WDATA    <= wdata_nx;
      MEMTOREG_OUT <= memtoreg_nx;
      REGWRITE_OUT <= regwrite_nx;
      RESULTOP_OUT <= resultop_nx;
      RDDATA_OUT   <= rddata_nx;
      ARD_OUT      <= ard_nx;
      MISALIGN_OUT <= mis_nx;
      TIMEOUT_OUT  <= tmo_nx;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - scoreboard bench for mem_stage_ctrl

module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        MEMWRITE_IN, MEMTOREG_IN, REGWRITE_IN;
  logic [31:0] RESULTOP_IN, WRDATA_IN;
  logic [4:0]  ARD_IN;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        MEM_ACK, STALL;
  logic        MEMTOREG_OUT, REGWRITE_OUT;
  logic [31:0] RESULTOP_OUT, RDDATA_OUT;
  logic [4:0]  ARD_OUT;
  logic        MISALIGN_OUT, TIMEOUT_OUT;

  mem_stage_ctrl #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .MEMWRITE_IN(MEMWRITE_IN), .MEMTOREG_IN(MEMTOREG_IN), .REGWRITE_IN(REGWRITE_IN),
    .RESULTOP_IN(RESULTOP_IN), .WRDATA_IN(WRDATA_IN), .ARD_IN(ARD_IN),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .STALL(STALL),
    .MEMTOREG_OUT(MEMTOREG_OUT), .REGWRITE_OUT(REGWRITE_OUT),
    .RESULTOP_OUT(RESULTOP_OUT), .RDDATA_OUT(RDDATA_OUT), .ARD_OUT(ARD_OUT),
    .MISALIGN_OUT(MISALIGN_OUT), .TIMEOUT_OUT(TIMEOUT_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall, req;
    logic        chk_mem;
    logic        we;
    logic [31:0] addr, wdata;
    logic        memtoreg, regwrite, mis, tmo;
    logic        chk_data;
    logic [31:0] resultop, rddata;
    logic [4:0]  ard;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  function automatic exp_t mk(string n, logic stall, logic req, logic we,
                              logic [31:0] addr, logic [31:0] wdata);
    exp_t e;
    e.name = n; e.stall = stall; e.req = req; e.chk_mem = req;
    e.we = we; e.addr = addr; e.wdata = wdata;
    e.memtoreg = 1'b0; e.regwrite = 1'b0; e.mis = 1'b0; e.tmo = 1'b0;
    e.chk_data = 1'b0; e.resultop = '0; e.rddata = '0; e.ard = '0;
    return e;
  endfunction

  function automatic exp_t wb(exp_t ei, logic m2r, logic rw, logic [31:0] res,
                              logic [31:0] rd, logic [4:0] ard, logic mis, logic tmo);
    exp_t e = ei;
    e.memtoreg = m2r; e.regwrite = rw; e.resultop = res; e.rddata = rd;
    e.ard = ard; e.mis = mis; e.tmo = tmo; e.chk_data = 1'b1;
    return e;
  endfunction

  function automatic exp_t zero_all(string n);
    exp_t e = wb(mk(n, 1'b0, 1'b0, 1'b0, '0, '0), 0, 0, '0, '0, '0, 0, 0);
    e.chk_mem = 1'b1;
    return e;
  endfunction

  // Monitor: every cycle the DUT presents a state at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk({cur.name, ".stall"}, 32'(STALL), 32'(cur.stall));
      chk({cur.name, ".mem_req"}, 32'(MEM_REQ), 32'(cur.req));
      if (cur.chk_mem) begin
        chk({cur.name, ".mem_we"}, 32'(MEM_WE), 32'(cur.we));
        chk({cur.name, ".mem_addr"}, MEM_ADDR, cur.addr);
        chk({cur.name, ".mem_wdata"}, MEM_WDATA, cur.wdata);
      end
      chk({cur.name, ".memtoreg"}, 32'(MEMTOREG_OUT), 32'(cur.memtoreg));
      chk({cur.name, ".regwrite"}, 32'(REGWRITE_OUT), 32'(cur.regwrite));
      chk({cur.name, ".misalign"}, 32'(MISALIGN_OUT), 32'(cur.mis));
      chk({cur.name, ".timeout"}, 32'(TIMEOUT_OUT), 32'(cur.tmo));
      if (cur.chk_data) begin
        chk({cur.name, ".resultop"}, RESULTOP_OUT, cur.resultop);
        chk({cur.name, ".rddata"}, RDDATA_OUT, cur.rddata);
        chk({cur.name, ".ard"}, 32'(ARD_OUT), 32'(cur.ard));
      end
    end
  end

  // One cycle: drive inputs just after the rising edge, queue the expectation.
  task automatic step(logic r, logic mw, logic m2r, logic rw, logic [31:0] res,
                      logic [31:0] wd, logic [4:0] ard, logic [31:0] rd,
                      logic ack, exp_t e);
    @(posedge clk);
    #1;
    rst = r; MEMWRITE_IN = mw; MEMTOREG_IN = m2r; REGWRITE_IN = rw;
    RESULTOP_IN = res; WRDATA_IN = wd; ARD_IN = ard; MEM_RDATA = rd; MEM_ACK = ack;
    sb.push_back(e);
  endtask

  task automatic nop(exp_t e);
    step(0, 0, 0, 0, '0, '0, '0, '0, 0, e);
  endtask

  initial begin
    rst = 1'b1;
    MEMWRITE_IN = 1'b1; MEMTOREG_IN = 1'b1; REGWRITE_IN = 1'b1;
    RESULTOP_IN = '0; WRDATA_IN = $urandom; ARD_IN = 5'd3;
    MEM_RDATA = $urandom; MEM_ACK = 1'b0;

    // Reset with random (including aligned memory-op) inputs
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 1'b1, 1'($urandom), {$urandom, 2'b00}, $urandom,
           5'($urandom), $urandom, 1'($urandom), zero_all("reset"));
    nop(zero_all("release"));

    // ALU passthrough
    step(0, 0, 0, 1, 32'hA5A5A5A5, '0, 5'b10101, '0, 0,
         wb(mk("alu_issue", 0, 0, 0, '0, '0), 0, 0, '0, '0, '0, 0, 0));

    // Load with ACK in the 3rd ACCESS cycle
    step(0, 0, 1, 1, 32'h100, '0, 5'b01010, 32'h12345678, 0,
         wb(mk("alu_wb", 1, 0, 0, '0, '0), 0, 1, 32'hA5A5A5A5, '0, 5'b10101, 0, 0));
    step(0, 0, 1, 1, 32'h100, '0, 5'b01010, 32'h12345678, 0, mk("ld_acc1", 1, 1, 0, 32'h100, '0));
    step(0, 0, 1, 1, 32'h100, '0, 5'b01010, 32'h12345678, 0, mk("ld_acc2", 1, 1, 0, 32'h100, '0));
    step(0, 0, 1, 1, 32'h100, '0, 5'b01010, 32'h12345678, 1, mk("ld_acc3", 0, 1, 0, 32'h100, '0));

    // Store with immediate ACK
    step(0, 1, 0, 0, 32'h40, 32'h55555555, '0, '0, 0,
         wb(mk("ld_wb", 1, 0, 0, '0, '0), 1, 1, 32'h100, 32'h12345678, 5'b01010, 0, 0));
    step(0, 1, 0, 0, 32'h40, 32'h55555555, '0, '0, 1,
         mk("st_acc1", 0, 1, 1, 32'h40, 32'h55555555));

    // Misaligned load
    step(0, 0, 1, 1, 32'h102, '0, 5'd3, '0, 0,
         wb(mk("st_wb", 0, 0, 0, '0, '0), 0, 0, 32'h40, '0, '0, 0, 0));
    // Stray ACK while idle must be ignored
    step(0, 0, 0, 0, '0, '0, '0, 32'hDEADBEEF, 1,
         wb(mk("misalign", 0, 0, 0, '0, '0), 0, 0, 32'h102, '0, 5'd3, 1, 0));

    // Load that never gets an ACK
    step(0, 0, 1, 1, 32'h200, '0, 5'd7, '0, 0,
         wb(mk("to_issue", 1, 0, 0, '0, '0), 0, 0, '0, '0, '0, 0, 0));
    for (int i = 0; i < 16; i++)
      step(0, 0, 1, 1, 32'h200, '0, 5'd7, '0, 0,
           mk($sformatf("to_acc%0d", i + 1), (i < 15), 1, 0, 32'h200, '0));
    nop(mk("to_fault", 0, 0, 0, '0, '0));
    cur = mk("to_fault", 0, 0, 0, '0, '0);
    void'(sb.pop_back());
    cur.tmo = 1'b1;
    sb.push_back(cur);
    nop(wb(mk("to_clear", 0, 0, 0, '0, '0), 0, 0, '0, '0, '0, 0, 0));

    // Reset asserted in the 5th ACCESS cycle
    step(0, 0, 1, 1, 32'h300, '0, 5'd9, '0, 0, mk("rs_issue", 1, 0, 0, '0, '0));
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 1, 32'h300, '0, 5'd9, '0, 0,
           mk($sformatf("rs_acc%0d", i + 1), 1, 1, 0, 32'h300, '0));
    step(1, 0, 1, 1, 32'h300, '0, 5'd9, '0, 0, zero_all("rs_mid"));
    nop(zero_all("rs_after"));

    // ACK coincides with the timeout limit: ACK wins
    step(0, 1, 0, 0, 32'h80, 32'h0000000A, '0, '0, 0, mk("lim_issue", 1, 0, 0, '0, '0));
    for (int i = 0; i < 15; i++)
      step(0, 1, 0, 0, 32'h80, 32'h0000000A, '0, '0, 0,
           mk($sformatf("lim_acc%0d", i + 1), 1, 1, 1, 32'h80, 32'h0000000A));
    step(0, 1, 0, 0, 32'h80, 32'h0000000A, '0, '0, 1,
         mk("lim_acc16", 0, 1, 1, 32'h80, 32'h0000000A));
    nop(wb(mk("lim_wb", 0, 0, 0, '0, '0), 0, 0, 32'h80, '0, '0, 0, 0));

    // Drain the scoreboard, bounded
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
